// File: rtl/irrigation_scheduler.sv
// Two-zone irrigation request scheduler: samples dry flags on a prescaled tick, requests valves,
// confirms the controller's echo, times the watering/cool windows, retries and locks out.
module irrigation_scheduler #(
  parameter int unsigned TICK_DIV    = 1000,
  parameter int unsigned WATER_TICKS = 60,
  parameter int unsigned COOL_TICKS  = 30,
  parameter int unsigned CONFIRM_CYC = 16,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [1:0] dry1,
  input  logic [1:0] dry2,
  input  logic [1:0] R1,
  input  logic [1:0] R2,
  input  logic [1:0] E,
  output logic [1:0] G1,
  output logic [1:0] G2,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic       err_seen
);

  localparam int unsigned PresW    = $clog2(TICK_DIV);
  localparam int unsigned MaxTicks = (WATER_TICKS > COOL_TICKS) ? WATER_TICKS : COOL_TICKS;
  localparam int unsigned TimerW   = $clog2(MaxTicks + 1);
  localparam int unsigned RetryW   = $clog2(MAX_RETRY + 1);
  localparam int unsigned ConfW    = $clog2(CONFIRM_CYC + 1);

  localparam logic [PresW-1:0]  PresLast  = PresW'(TICK_DIV - 1);
  localparam logic [TimerW-1:0] WaterLast = TimerW'(WATER_TICKS - 1);
  localparam logic [TimerW-1:0] CoolLast  = TimerW'(COOL_TICKS - 1);
  localparam logic [RetryW-1:0] RetryMax  = RetryW'(MAX_RETRY);
  localparam logic [ConfW-1:0]  ConfLast  = ConfW'(CONFIRM_CYC - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRequest,
    StRetry,
    StWater,
    StCool,
    StEwait,
    StLockout
  } state_e;

  state_e state_q, state_d;

  logic [PresW-1:0]  pres_q;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [RetryW-1:0] retry_q, retry_d, retry_inc;
  logic [ConfW-1:0]  conf_q, conf_d;
  logic [1:0]        req1_q, req1_d, req2_q, req2_d;

  logic       tick;
  logic       ctrl_err;
  logic       match;
  logic       done_evt;
  logic [1:0] g1_d, g2_d;
  logic       busy_d, fault_d;

  assign tick     = (pres_q == PresLast);
  assign ctrl_err = (E != 2'b01);

  // A request touching both sub-zones of either zone makes the controller open everything.
  always_comb begin
    if (req1_q == 2'b11 || req2_q == 2'b11) begin
      match = (R1 == 2'b11) && (R2 == 2'b11);
    end else begin
      match = (R1 == req1_q) && (R2 == req2_q);
    end
  end

  assign retry_inc = (retry_q == RetryMax) ? retry_q : retry_q + RetryW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pres_q <= '0;
    end else if (tick) begin
      pres_q <= '0;
    end else begin
      pres_q <= pres_q + PresW'(1);
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      timer_q <= '0;
      retry_q <= '0;
      conf_q  <= '0;
      req1_q  <= '0;
      req2_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      conf_q  <= conf_d;
      req1_q  <= req1_d;
      req2_q  <= req2_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    retry_d  = retry_q;
    conf_d   = conf_q;
    req1_d   = req1_q;
    req2_d   = req2_q;
    done_evt = 1'b0;

    if (ctrl_err && (state_q inside {StRequest, StRetry, StWater, StCool})) begin
      state_d = StEwait;
    end else if (!en && state_q != StLockout) begin
      state_d = StIdle;
      retry_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (tick && ((dry1 | dry2) != 2'b00)) begin
            req1_d  = dry1;
            req2_d  = dry2;
            conf_d  = '0;
            state_d = StRequest;
          end
        end
        StRequest: begin
          if (match) begin
            timer_d = '0;
            state_d = StWater;
          end else if (conf_q == ConfLast) begin
            retry_d = retry_inc;
            state_d = StRetry;
          end else begin
            conf_d = conf_q + ConfW'(1);
          end
        end
        StRetry: begin
          if (retry_q == RetryMax) begin
            state_d = StLockout;
          end else begin
            conf_d  = '0;
            state_d = StRequest;
          end
        end
        StWater: begin
          if (!match) begin
            retry_d = retry_inc;
            state_d = StRetry;
          end else if (tick) begin
            if (timer_q == WaterLast) begin
              timer_d  = '0;
              retry_d  = '0;
              done_evt = 1'b1;
              state_d  = StCool;
            end else begin
              timer_d = timer_q + TimerW'(1);
            end
          end
        end
        StCool: begin
          if (tick) begin
            if (timer_q == CoolLast) begin
              state_d = StIdle;
            end else begin
              timer_d = timer_q + TimerW'(1);
            end
          end
        end
        StEwait: begin
          if (!ctrl_err) begin
            state_d = StIdle;
          end
        end
        StLockout: begin
          if (!en) begin
            retry_d = '0;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Output logic, decoded from the next state so every output can be registered
  always_comb begin
    g1_d    = 2'b00;
    g2_d    = 2'b00;
    busy_d  = !(state_d inside {StIdle, StLockout});
    fault_d = (state_d == StLockout);
    if (state_d inside {StRequest, StWater}) begin
      g1_d = req1_d;
      g2_d = req2_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      G1       <= 2'b00;
      G2       <= 2'b00;
      busy     <= 1'b0;
      done     <= 1'b0;
      fault    <= 1'b0;
      err_seen <= 1'b0;
    end else begin
      G1       <= g1_d;
      G2       <= g2_d;
      busy     <= busy_d;
      done     <= done_evt;
      fault    <= fault_d;
      err_seen <= err_seen | ctrl_err;
    end
  end

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Directed bench for irrigation_scheduler: expected output vectors are queued as stimulus is
// applied and popped against the DUT on falling clock edges.
module tb_irrigation_scheduler;

  localparam int unsigned TD = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic [1:0] dry1, dry2, R1, R2, E;
  logic [1:0] G1, G2;
  logic       busy, done, fault, err_seen;
  logic [7:0] obs;

  int tests_run = 0;
  int failures  = 0;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  assign obs = {G1, G2, busy, done, fault, err_seen};

  irrigation_scheduler #(
    .TICK_DIV   (TD),
    .WATER_TICKS(3),
    .COOL_TICKS (2),
    .CONFIRM_CYC(8),
    .MAX_RETRY  (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .dry1    (dry1),
    .dry2    (dry2),
    .R1      (R1),
    .R2      (R2),
    .E       (E),
    .G1      (G1),
    .G2      (G2),
    .busy    (busy),
    .done    (done),
    .fault   (fault),
    .err_seen(err_seen)
  );

  function automatic logic [7:0] o(input logic [1:0] g1, input logic [1:0] g2, input logic b,
                                   input logic d, input logic f, input logic e);
    return {g1, g2, b, d, f, e};
  endfunction

  task automatic check_vec(input string tag, input logic [7:0] got, input logic [7:0] want);
    tests_run++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s: observed G1G2_busy_done_fault_err=%b expected %b", tag, got, want);
    end
  endtask

  task automatic check_rng(input string tag, input int got, input int lo, input int hi);
    tests_run++;
    assert ((got >= lo) && (got <= hi)) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, got, lo, hi);
    end
  endtask

  task automatic expect_v(input string tag, input logic [7:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      check_vec(e.tag, obs, e.val);
    end
  endtask

  // Waits on falling edges for (obs & mask) == val; n = edges consumed, -1 on timeout.
  task automatic wait_obs(input logic [7:0] mask, input logic [7:0] val, input int budget,
                          output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if ((obs & mask) == val) begin
        n = i;
        break;
      end
    end
  endtask

  // Unanswered request: rest of first REQUEST, gap, second REQUEST, gap, then lockout.
  task automatic push_rounds(input string tag, input logic [1:0] g1, input logic e);
    for (int i = 0; i < 7; i++) expect_v({tag, "_req_a"}, o(g1, 2'b00, 1, 0, 0, e));
    expect_v({tag, "_gap_a"}, o(2'b00, 2'b00, 1, 0, 0, e));
    for (int i = 0; i < 8; i++) expect_v({tag, "_req_b"}, o(g1, 2'b00, 1, 0, 0, e));
    expect_v({tag, "_gap_b"}, o(2'b00, 2'b00, 1, 0, 0, e));
    expect_v({tag, "_lock"}, o(2'b00, 2'b00, 0, 0, 1, e));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int cnt;
    reset_n = 1'b0;
    en      = 1'b0;
    dry1    = 2'b00;
    dry2    = 2'b00;
    R1      = 2'b00;
    R2      = 2'b00;
    E       = 2'b01;
    #2;
    check_vec("reset", obs, 8'h00);

    // 1: single sub-zone request, echoed, full window and cool-down
    @(negedge clk);
    reset_n = 1'b1;
    en      = 1'b1;
    dry1    = 2'b01;
    R1      = 2'b01;
    wait_obs(8'hC0, 8'h40, 8, n);
    check_rng("t1_first_tick", n, TD, TD);
    check_vec("t1_req", obs, o(2'b01, 2'b00, 1, 0, 0, 0));
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (G1 == 2'b01) cnt++;
      else break;
    end
    check_rng("t1_water_len", cnt, 9, 12);
    check_vec("t1_done", obs, o(2'b00, 2'b00, 1, 1, 0, 0));
    dry1 = 2'b00;
    R1   = 2'b00;
    expect_v("t1_done_once", o(2'b00, 2'b00, 1, 0, 0, 0));
    drain();
    wait_obs(8'h08, 8'h00, 12, n);
    check_rng("t1_cool_len", (n < 0) ? -1 : n + 1, 5, 8);
    check_vec("t1_idle", obs, 8'h00);

    // 2: both-sub-zone request needs full 11/11 echo
    dry1 = 2'b10;
    dry2 = 2'b11;
    R1   = 2'b11;
    R2   = 2'b11;
    wait_obs(8'hF0, 8'hB0, 8, n);
    check_rng("t2_req", n, 1, TD);
    for (int i = 0; i < 8; i++) expect_v("t2_confirmed_hold", o(2'b10, 2'b11, 1, 0, 0, 0));
    drain();
    wait_obs(8'h04, 8'h04, 16, n);
    check_rng("t2_window_done", n, 2, 5);
    R1 = 2'b10;
    R2 = 2'b11;
    wait_obs(8'hF0, 8'hB0, 16, n);
    check_rng("t2_rereq", n, 6, 12);
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (G1 == 2'b10 && G2 == 2'b11) cnt++;
      else break;
    end
    check_rng("t2_no_confirm_len", cnt, 8, 8);
    check_vec("t2_retry_gap", obs, o(2'b00, 2'b00, 1, 0, 0, 0));
    expect_v("t2_rerequest", o(2'b10, 2'b11, 1, 0, 0, 0));
    drain();
    en   = 1'b0;
    dry1 = 2'b00;
    dry2 = 2'b00;
    R1   = 2'b00;
    R2   = 2'b00;
    expect_v("t2_abort_idle", 8'h00);
    drain();

    // 3: no response -> two rounds then lockout; en low for one cycle clears it
    en   = 1'b1;
    dry1 = 2'b01;
    wait_obs(8'hC0, 8'h40, 8, n);
    check_rng("t3_req", n, 1, TD);
    push_rounds("t3", 2'b01, 1'b0);
    for (int i = 0; i < 5; i++) expect_v("t3_lock_hold", o(2'b00, 2'b00, 0, 0, 1, 0));
    drain();
    en = 1'b0;
    expect_v("t3_unlock", 8'h00);
    drain();

    // 4: controller error during WATER
    en   = 1'b1;
    R1   = 2'b01;
    wait_obs(8'hC0, 8'h40, 8, n);
    check_rng("t4_req", n, 1, TD);
    for (int i = 0; i < 3; i++) expect_v("t4_water", o(2'b01, 2'b00, 1, 0, 0, 0));
    drain();
    E = 2'b00;
    for (int i = 0; i < 3; i++) expect_v("t4_ewait", o(2'b00, 2'b00, 1, 0, 0, 1));
    drain();
    E    = 2'b01;
    dry1 = 2'b00;
    for (int i = 0; i < 3; i++) expect_v("t4_idle_sticky", o(2'b00, 2'b00, 0, 0, 0, 1));
    drain();

    // 5: lost confirmation in WATER -> retry; completion clears the retry count
    dry1 = 2'b01;
    wait_obs(8'hC0, 8'h40, 8, n);
    check_rng("t5_req", n, 1, TD);
    for (int i = 0; i < 2; i++) expect_v("t5_water", o(2'b01, 2'b00, 1, 0, 0, 1));
    drain();
    R1 = 2'b00;
    expect_v("t5_retry", o(2'b00, 2'b00, 1, 0, 0, 1));
    drain();
    R1 = 2'b01;
    expect_v("t5_rerequest", o(2'b01, 2'b00, 1, 0, 0, 1));
    drain();
    wait_obs(8'h04, 8'h04, 16, n);
    check_rng("t5_done_delay", n, 10, 13);
    check_vec("t5_done", obs, o(2'b00, 2'b00, 1, 1, 0, 1));
    R1 = 2'b00;
    wait_obs(8'hC0, 8'h40, 16, n);
    check_rng("t5_next_req", n, 6, 12);
    push_rounds("t5_full_budget", 2'b01, 1'b1);
    drain();
    en = 1'b0;
    expect_v("t5_unlock", o(2'b00, 2'b00, 0, 0, 0, 1));
    drain();

    // 6: asynchronous reset in the middle of WATER
    en = 1'b1;
    R1 = 2'b01;
    wait_obs(8'hC0, 8'h40, 8, n);
    check_rng("t6_req", n, 1, TD);
    for (int i = 0; i < 2; i++) expect_v("t6_water", o(2'b01, 2'b00, 1, 0, 0, 1));
    drain();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_vec("t6_async_reset", obs, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    wait_obs(8'hC0, 8'h40, 8, n);
    check_rng("t6_first_tick", n, TD, TD);
    check_vec("t6_req", obs, o(2'b01, 2'b00, 1, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
